function_expander: RTL and testbench

- Expands a function-call packet into the packet requests that start the called function.
- Accepts one call packet and fetches a 95-bit function descriptor from memory as three 32-bit reads.
- Allocates a fresh 16-bit color and emits up to five packet requests: coloring, returning, arg1, arg2, exec.
- Sits between the packet dispatch stage and the packet-request network, with a read port to main memory.

---
 rtl/function_expander.sv | 175 +++++++++++++++++
 tb/tb_function_expander.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/function_expander.sv
// function_expander: turns a call packet into the packet requests
// that start the called function (descriptor fetch + color alloc).
module function_expander #(
  parameter int         OPCODE_WIDTH         = 6,
  parameter int         PACKET_WIDTH         = OPCODE_WIDTH+10+4*32+3+16+16,
  parameter int         PACKET_REQUEST_WIDTH = 99,
  parameter int         FUNCTION_WIDTH       = 95,
  parameter logic [2:0] DEST_OPTION_NOP      = 3'b000
) (
  input  logic                            CLK,
  input  logic                            RST,
  input  logic [31:0]                     FNADDR,
  input  logic                            RECEIVE_PC_VALID,
  input  logic [PACKET_WIDTH-1:0]         RECEIVE_PC_DATA,
  output logic                            RECEIVE_PC_READY,
  output logic                            SEND_PR_VALID,
  output logic [PACKET_REQUEST_WIDTH-1:0] SEND_PR_DATA,
  input  logic                            SEND_PR_READY,
  output logic                            MEM_SEND_ADDR_VALID,
  output logic [31:0]                     MEM_SEND_ADDR,
  output logic                            MEM_SEND_DATA_VALID,
  output logic [31:0]                     MEM_SEND_DATA,
  input  logic                            MEM_SEND_READY,
  input  logic                            MEM_RECEIVE_VALID,
  input  logic [31:0]                     MEM_RECEIVE_DATA,
  output logic                            MEM_RECEIVE_READY
);

  localparam int FNIDX_LSB = PACKET_WIDTH - OPCODE_WIDTH - 10;
  localparam int D1_LSB    = FNIDX_LSB - 32;
  localparam int D2_LSB    = D1_LSB - 32;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_RESP,
    S_EMIT
  } state_t;

  state_t state_q, state_d;
  logic [2:0] idx_q, idx_d;

  logic [9:0]  fnidx_q;
  logic [31:0] data1_q, data2_q;
  logic [2:0]  dopt_q;
  logic [15:0] daddr_q, color_q;
  logic [15:0] color_cnt, new_color;
  logic [15:0] cnt_inc;
  logic [FUNCTION_WIDTH-1:0] fn_q;

  logic        pc_fire;
  logic        slot_live;
  logic [18:0] slot_dest;
  logic [15:0] slot_color;
  logic [31:0] slot_d1;

  // opcode, data3/data4 and the top bit of word 2 carry nothing we need
  logic unused_bits;
  assign unused_bits = ^{RECEIVE_PC_DATA[PACKET_WIDTH-1:FNIDX_LSB+10],
                         RECEIVE_PC_DATA[D2_LSB-1:35],
                         MEM_RECEIVE_DATA[31]};

  assign RECEIVE_PC_READY    = (state_q == S_IDLE) && !RST;
  assign pc_fire             = RECEIVE_PC_VALID && RECEIVE_PC_READY;
  assign MEM_SEND_ADDR_VALID = (state_q == S_REQ);
  assign MEM_RECEIVE_READY   = (state_q == S_RESP);
  assign MEM_SEND_DATA_VALID = 1'b0;
  assign MEM_SEND_DATA       = 32'h0;
  assign MEM_SEND_ADDR       = FNADDR + {22'h0, fnidx_q}
                             + {27'h0, idx_q, 2'b00};

  assign cnt_inc = (color_cnt == 16'hFFFF) ? 16'd1 : color_cnt + 16'd1;

  // state register and fetch/slot index
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      idx_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // next state: three fetches, then five emit slots
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      S_IDLE: begin
        if (pc_fire) begin
          state_d = S_REQ;
          idx_d   = 3'd0;
        end
      end
      S_REQ: begin
        if (MEM_SEND_READY) state_d = S_RESP;
      end
      S_RESP: begin
        if (MEM_RECEIVE_VALID) begin
          if (idx_q == 3'd2) begin
            state_d = S_EMIT;
            idx_d   = 3'd0;
          end else begin
            state_d = S_REQ;
            idx_d   = idx_q + 3'd1;
          end
        end
      end
      S_EMIT: begin
        if (!slot_live || SEND_PR_READY) begin
          if (idx_q == 3'd4) state_d = S_IDLE;
          else idx_d = idx_q + 3'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // call context, color allocation and descriptor capture
  always_ff @(posedge CLK) begin
    if (RST) begin
      color_cnt <= 16'h0;
      new_color <= 16'h0;
    end else if (pc_fire) begin
      fnidx_q   <= RECEIVE_PC_DATA[FNIDX_LSB +: 10];
      data1_q   <= RECEIVE_PC_DATA[D1_LSB +: 32];
      data2_q   <= RECEIVE_PC_DATA[D2_LSB +: 32];
      dopt_q    <= RECEIVE_PC_DATA[34:32];
      daddr_q   <= RECEIVE_PC_DATA[31:16];
      color_q   <= RECEIVE_PC_DATA[15:0];
      color_cnt <= cnt_inc;
      new_color <= cnt_inc;
    end else if (state_q == S_RESP && MEM_RECEIVE_VALID) begin
      unique case (idx_q)
        3'd0:    fn_q[94:63] <= MEM_RECEIVE_DATA;
        3'd1:    fn_q[62:31] <= MEM_RECEIVE_DATA;
        default: fn_q[30:0]  <= MEM_RECEIVE_DATA[30:0];
      endcase
    end
  end

  // request content for the current emit slot
  always_comb begin
    slot_dest  = fn_q[94:76];
    slot_color = new_color;
    slot_d1    = {16'h0, color_q};
    unique case (idx_q)
      3'd1: begin
        slot_dest  = fn_q[75:57];
        slot_color = color_q;
        slot_d1    = {13'h0, dopt_q, daddr_q};
      end
      3'd2: begin
        slot_dest = fn_q[56:38];
        slot_d1   = data1_q;
      end
      3'd3: begin
        slot_dest = fn_q[37:19];
        slot_d1   = data2_q;
      end
      3'd4: begin
        slot_dest = fn_q[18:0];
        slot_d1   = 32'h0;
      end
      default: ;
    endcase
  end

  assign slot_live     = (idx_q < 3'd2)
                      || (slot_dest[18:16] != DEST_OPTION_NOP);
  assign SEND_PR_VALID = (state_q == S_EMIT) && slot_live;
  assign SEND_PR_DATA  = {slot_dest, slot_color, slot_d1, 32'h0};

endmodule

// File: tb/tb_function_expander.sv
// tb_function_expander: random calls against a queue-based model
// of the requests each call must produce.
module tb_function_expander;

  localparam int PW = 179;
  localparam int RW = 99;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   fnaddr;
  logic          pc_valid;
  logic [PW-1:0] pc_data;
  logic          pc_ready;
  logic          pr_valid;
  logic [RW-1:0] pr_data;
  logic          pr_ready;
  logic          ma_valid;
  logic [31:0]   ma_addr;
  logic          md_valid;
  logic [31:0]   md_data;
  logic          ma_ready;
  logic          mr_valid;
  logic [31:0]   mr_data;
  logic          mr_ready;

  int vectors = 0;
  int miscompares = 0;
  logic [15:0] model_cnt;

  always #5 clk = ~clk;

  function_expander dut (
    .CLK                 (clk),
    .RST                 (rst),
    .FNADDR              (fnaddr),
    .RECEIVE_PC_VALID    (pc_valid),
    .RECEIVE_PC_DATA     (pc_data),
    .RECEIVE_PC_READY    (pc_ready),
    .SEND_PR_VALID       (pr_valid),
    .SEND_PR_DATA        (pr_data),
    .SEND_PR_READY       (pr_ready),
    .MEM_SEND_ADDR_VALID (ma_valid),
    .MEM_SEND_ADDR       (ma_addr),
    .MEM_SEND_DATA_VALID (md_valid),
    .MEM_SEND_DATA       (md_data),
    .MEM_SEND_READY      (ma_ready),
    .MEM_RECEIVE_VALID   (mr_valid),
    .MEM_RECEIVE_DATA    (mr_data),
    .MEM_RECEIVE_READY   (mr_ready)
  );

  task automatic check(input string tag,
                       input logic [127:0] got,
                       input logic [127:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // colors run 1..65535 and never 0
  function automatic logic [15:0] next_color(input logic [15:0] c);
    return 16'((int'(c) % 65535) + 1);
  endfunction

  task automatic run_call(input logic [9:0]  fnidx,
                          input logic [31:0] d1,
                          input logic [31:0] d2,
                          input logic [2:0]  dopt,
                          input logic [15:0] daddr,
                          input logic [15:0] color,
                          input logic [94:0] fn,
                          input logic [15:0] newc,
                          input bit          stall);
    logic [98:0] expq[$];
    logic [31:0] w[3];
    logic [31:0] a;
    logic [98:0] snap;
    int n;
    int got;
    int extra;
    w[0] = fn[94:63];
    w[1] = fn[62:31];
    w[2] = {1'($urandom), fn[30:0]};
    expq.push_back({fn[94:76], newc, 16'h0, color, 32'h0});
    expq.push_back({fn[75:57], color, 13'h0, dopt, daddr, 32'h0});
    if (fn[56:54] != 3'b000)
      expq.push_back({fn[56:38], newc, d1, 32'h0});
    if (fn[37:35] != 3'b000)
      expq.push_back({fn[37:19], newc, d2, 32'h0});
    if (fn[18:16] != 3'b000)
      expq.push_back({fn[18:0], newc, 64'h0});

    @(negedge clk);
    pc_valid = 1'b1;
    pc_data  = {6'($urandom), fnidx, d1, d2,
                32'($urandom), 32'($urandom),
                dopt, daddr, color};
    n = 0;
    while (!pc_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("accept_timeout", 128'(n < 50), 128'(1));
    @(negedge clk);
    pc_valid = 1'b0;
    check("busy_after_accept", 128'(pc_ready), 128'(0));

    for (int k = 0; k < 3; k++) begin
      n = 0;
      while (!ma_valid && n < 50) begin
        @(negedge clk);
        n++;
      end
      a = fnaddr + {22'h0, fnidx} + 32'(4 * k);
      check($sformatf("addr%0d", k), 128'(ma_addr), 128'(a));
      if (stall) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        check($sformatf("addr_hold%0d", k),
              128'({ma_valid, ma_addr}), 128'({1'b1, a}));
      end
      ma_ready = 1'b1;
      @(negedge clk);
      ma_ready = 1'b0;
      check($sformatf("one_outstanding%0d", k),
            128'(ma_valid), 128'(0));
      if (stall) repeat ($urandom_range(0, 3)) @(negedge clk);
      mr_valid = 1'b1;
      mr_data  = w[k];
      n = 0;
      while (!mr_ready && n < 50) begin
        @(negedge clk);
        n++;
      end
      check($sformatf("resp_ready%0d", k), 128'(mr_ready), 128'(1));
      @(negedge clk);
      mr_valid = 1'b0;
      mr_data  = $urandom;
    end

    got = 0;
    n   = 0;
    while (got < expq.size() && n < 100) begin
      if (pr_valid) begin
        if (stall && $urandom_range(0, 1) == 1) begin
          snap = pr_data;
          repeat ($urandom_range(1, 3)) @(negedge clk);
          check($sformatf("req_hold%0d", got),
                128'({pr_valid, pr_data}), 128'({1'b1, snap}));
        end
        check($sformatf("req%0d", got), 128'(pr_data), 128'(expq[got]));
        pr_ready = 1'b1;
        @(negedge clk);
        pr_ready = 1'b0;
        got++;
      end else begin
        @(negedge clk);
        n++;
      end
    end
    check("req_count", 128'(got), 128'(expq.size()));

    extra = 0;
    n = 0;
    while (!pc_ready && n < 20) begin
      if (pr_valid) extra++;
      @(negedge clk);
      n++;
    end
    check("no_extra_req", 128'(extra), 128'(0));
    check("back_to_idle", 128'(pc_ready), 128'(1));
  endtask

  initial begin : stim
    logic [94:0] fn;
    logic [15:0] nc;
    int n;
    int seen;
    rst      = 1'b1;
    fnaddr   = 32'h1000;
    pc_valid = 1'b0;
    pc_data  = '0;
    pr_ready = 1'b0;
    ma_ready = 1'b0;
    mr_valid = 1'b0;
    mr_data  = '0;
    model_cnt = 16'h0;

    @(negedge clk);
    check("rst_pc_ready", 128'(pc_ready), 128'(0));
    check("rst_ma_valid", 128'(ma_valid), 128'(0));
    check("rst_pr_valid", 128'(pr_valid), 128'(0));
    check("rst_mr_ready", 128'(mr_ready), 128'(0));
    rst = 1'b0;
    #1;
    check("post_rst_ready", 128'(pc_ready), 128'(1));
    check("wdata_tied", 128'({md_valid, md_data}), 128'(0));

    // full call, all slots live; returning data1 = 0x00020010
    fn = {3'd1, 16'h0100, 3'd2, 16'h0200, 3'd3, 16'h0300,
          3'd4, 16'h0400, 3'd5, 16'h0500};
    model_cnt = next_color(model_cnt);
    check("first_color", 128'(model_cnt), 128'(1));
    run_call(10'h005, 32'hAAAA5555, 32'h12345678, 3'd2,
             16'h0010, 16'h0042, fn, model_cnt, 1'b0);

    // arg2 NOP, back-to-back, with stalls
    fn[37:35] = 3'b000;
    model_cnt = next_color(model_cnt);
    run_call(10'h3FF, 32'h0BADF00D, 32'hDEADBEEF, 3'd7,
             16'hFFFF, 16'h1234, fn, model_cnt, 1'b1);

    // random calls, random NOP options on every slot
    for (int i = 0; i < 16; i++) begin
      fn = {$urandom, $urandom, $urandom};
      for (int s = 0; s < 5; s++)
        if ($urandom_range(0, 2) == 0) fn[94 - 19*s -: 3] = 3'b000;
      fnaddr = (i % 4 == 0) ? 32'hFFFF_FFF8 : $urandom;
      model_cnt = next_color(model_cnt);
      run_call(10'($urandom), $urandom, $urandom, 3'($urandom),
               16'($urandom), 16'($urandom), fn, model_cnt, 1'b1);
    end

    // reset in the middle of a fetch abandons the call
    @(negedge clk);
    pc_valid = 1'b1;
    pc_data  = {PW{1'b1}};
    @(negedge clk);
    pc_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_cnt = 16'h0;
    seen = 0;
    ma_ready = 1'b1;
    pr_ready = 1'b1;
    for (int c = 0; c < 15; c++) begin
      if (ma_valid || pr_valid) seen++;
      @(negedge clk);
    end
    ma_ready = 1'b0;
    pr_ready = 1'b0;
    check("mid_rst_silent", 128'(seen), 128'(0));
    check("mid_rst_idle", 128'(pc_ready), 128'(1));

    fn = {$urandom, $urandom, $urandom};
    fnaddr = 32'h2000;
    model_cnt = next_color(model_cnt);
    run_call(10'h011, $urandom, $urandom, 3'd1,
             16'h0020, 16'h0007, fn, model_cnt, 1'b1);

    // counter at 0xFFFF must wrap to color 1
    @(negedge clk);
    force dut.color_cnt = 16'hFFFF;
    nc = next_color(16'hFFFF);
    check("wrap_model", 128'(nc), 128'(1));
    fn = {$urandom, $urandom, $urandom};
    run_call(10'h0AA, $urandom, $urandom, 3'd3,
             16'h0100, 16'h0099, fn, nc, 1'b0);
    release dut.color_cnt;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    while (!pc_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("final_idle", 128'(pc_ready), 128'(1));

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
